// File: rtl/banked_reg_file.sv
// Multi-context register file: NUM_BANKS banks of 2**ADDR_W registers, three
// bypassed read ports, one write port and a background bank-clear sequencer.
module banked_reg_file #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 6,
    parameter int BANK_W = 2
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Reg_Write,
    input  logic [ADDR_W-1:0] Write_Addr,
    input  logic [DATA_W-1:0] Write_Data,
    input  logic [ADDR_W-1:0] Read_Addr_1,
    input  logic [ADDR_W-1:0] Read_Addr_2,
    input  logic [ADDR_W-1:0] Read_Addr_3,
    output logic [DATA_W-1:0] Read_Data_1,
    output logic [DATA_W-1:0] Read_Data_2,
    output logic [DATA_W-1:0] Read_Data_3,
    input  logic              Bank_Switch,
    input  logic [BANK_W-1:0] Bank_Sel,
    output logic [BANK_W-1:0] Active_Bank,
    input  logic              Clear_Req,
    input  logic [BANK_W-1:0] Clear_Bank,
    output logic              Busy,
    output logic              Clear_Done
);

    localparam int                NUM_BANKS = 2 ** BANK_W;
    localparam int                NUM_REGS  = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_REGS - 1);

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        DONE
    } clr_state_t;

    clr_state_t        state;
    clr_state_t        state_next;
    logic [BANK_W-1:0] active_bank;
    logic [BANK_W-1:0] clr_bank;
    logic [ADDR_W-1:0] idx;
    logic [DATA_W-1:0] regs [NUM_BANKS][NUM_REGS];

    logic              write_blocked;
    logic              write_en;
    logic [ADDR_W-1:0] rd_addr [3];
    logic [DATA_W-1:0] rd_data [3];

    // A write aimed at the bank under clear is discarded, bypass included, so
    // a half-cleared bank can never be repopulated behind the sequencer.
    assign write_blocked = (state == CLEAR) && (active_bank == clr_bank);
    assign write_en      = Reg_Write && (Write_Addr != '0) && !write_blocked;

    // ---------------------------------------------------------------
    // Clear sequencer
    // ---------------------------------------------------------------
    // NOTE: state-holding elements use non-blocking assignments so every flop
    // samples the pre-edge values; blocking here would create ordering races.
    always_ff @(posedge Clock) begin
        if (Reset) state <= IDLE;
        else       state <= state_next;
    end

    // NOTE: next-state is defaulted before the case so every path assigns it
    // and no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (Clear_Req) state_next = CLEAR;
            CLEAR:   if (idx == LAST_IDX) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            clr_bank <= '0;
            idx      <= FIRST_IDX;
        end else if (state == IDLE && Clear_Req) begin
            clr_bank <= Clear_Bank;
            idx      <= FIRST_IDX;
        end else if (state == CLEAR && idx != LAST_IDX) begin
            idx <= idx + FIRST_IDX;
        end
    end

    assign Busy       = (state == CLEAR);
    assign Clear_Done = (state == DONE);

    // ---------------------------------------------------------------
    // Active bank
    // ---------------------------------------------------------------
    always_ff @(posedge Clock) begin
        if (Reset)            active_bank <= '0;
        else if (Bank_Switch) active_bank <= Bank_Sel;
    end

    assign Active_Bank = active_bank;

    // ---------------------------------------------------------------
    // Register storage
    // ---------------------------------------------------------------
    // NOTE: the whole array is reset because software relies on every context
    // starting from zero; this forces flops rather than a RAM macro.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                for (int r = 0; r < NUM_REGS; r++) begin
                    regs[b][r] <= '0;
                end
            end
        end else begin
            if (write_en) regs[active_bank][Write_Addr] <= Write_Data;
            // Never collides with the port write: that one is blocked when
            // it targets the bank being cleared.
            if (state == CLEAR) regs[clr_bank][idx] <= '0;
        end
    end

    // ---------------------------------------------------------------
    // Read ports with write-through bypass
    // ---------------------------------------------------------------
    assign rd_addr[0] = Read_Addr_1;
    assign rd_addr[1] = Read_Addr_2;
    assign rd_addr[2] = Read_Addr_3;

    always_comb begin
        for (int p = 0; p < 3; p++) begin
            rd_data[p] = '0;
            if (rd_addr[p] != '0) begin
                if (write_en && Write_Addr == rd_addr[p]) rd_data[p] = Write_Data;
                else                                      rd_data[p] = regs[active_bank][rd_addr[p]];
            end
        end
    end

    assign Read_Data_1 = rd_data[0];
    assign Read_Data_2 = rd_data[1];
    assign Read_Data_3 = rd_data[2];

endmodule

// File: doc/banked_reg_file.md
Name: banked_reg_file

Overview:
Parametrised multi-context register file for the processor. It supersedes the single-bank 64x32 file. It holds NUM_BANKS independent register banks, one per hardware/OS context, selected by an active-bank register. It provides three read ports with write-through bypass, one synchronous write port, and a background clear sequencer that zeroes one bank while the others stay usable.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 6, register index width; each bank holds 2**ADDR_W registers
BANK_W, 2, bank index width; NUM_BANKS = 2**BANK_W

Ports:
Clock  input  1  single system clock; all state updates on rising edge
Reset  input  1  reset Reset, synchronous, active-high
Reg_Write  input  1  write enable for the active bank
Write_Addr  input  ADDR_W  write register index
Write_Data  input  DATA_W  write data, signed
Read_Addr_1  input  ADDR_W  read port 1 index (ports 2 and 3 identical)
Read_Addr_2  input  ADDR_W  read port 2 index
Read_Addr_3  input  ADDR_W  read port 3 index
Read_Data_1  output  DATA_W  read port 1 data, signed (ports 2 and 3 identical)
Read_Data_2  output  DATA_W  read port 2 data
Read_Data_3  output  DATA_W  read port 3 data
Bank_Switch  input  1  strobe: load Bank_Sel into the active bank
Bank_Sel  input  BANK_W  new active bank
Active_Bank  output  BANK_W  current active bank
Clear_Req  input  1  strobe: start clearing bank Clear_Bank
Clear_Bank  input  BANK_W  bank to clear
Busy  output  1  clear sequencer running
Clear_Done  output  1  one-cycle pulse when clear completes

Behaviour:
- Register 0 of every bank reads 0 always. Writes to index 0 are discarded.
- Reads are combinational from the active bank.
- Bypass: if Reg_Write=1 and Write_Addr==Read_Addr_n!=0 and the write is not dropped, Read_Data_n=Write_Data in the same cycle.
- Write: at the rising edge with Reg_Write=1 and Write_Addr!=0, bank[Active_Bank][Write_Addr] <= Write_Data.
- Bank_Switch: Active_Bank <= Bank_Sel at the edge. A write or read in the same cycle uses the old bank. The new bank is effective the next cycle.
- Clear FSM states: IDLE, CLEAR, DONE.
  - IDLE: Clear_Req=1 -> CLEAR, latch Clear_Bank into clr_bank, idx <= 1.
  - CLEAR: each edge writes bank[clr_bank][idx] <= 0 and idx <= idx+1. At idx = 2**ADDR_W-1, the write is done and the state goes to DONE.
  - DONE: Clear_Done=1 for exactly one cycle -> IDLE.
- Timing for ADDR_W=6: Clear_Req sampled at edge k; Busy=1 from k to k+63 (63 cycles); Clear_Done=1 in the cycle after edge k+63.
- Busy=1 exactly in CLEAR.
- Clear_Req in CLEAR or DONE is ignored, with no queueing.
- Writes while Busy=1 and Active_Bank==clr_bank are dropped entirely, at all indices, including bypass. Writes to other banks proceed normally.
- Reads of the bank being cleared return the partial state: indices < idx read 0, the rest read old values.
- Bank_Switch is legal at any time, including into or out of the bank being cleared.
- Reset at an edge: every register in every bank <= 0, Active_Bank <= 0, FSM <= IDLE, idx <= 1, Busy=0, Clear_Done=0. Reset has priority over write, switch and clear. A clear in progress is aborted without a Clear_Done pulse.
- All arithmetic is unsigned on indices. idx never wraps past 2**ADDR_W-1.

Test Plan:
- Bypass and write: Reset, then Reg_Write=1, Write_Addr=5, Write_Data=-7, Read_Addr_1=5 -> Read_Data_1=-7 in the same cycle. Next cycle with Reg_Write=0 -> still -7.
- Register 0: write 0x1234 to index 0 -> Read_Data_2 at index 0 = 0, with no bypass.
- Bank isolation: write 10 to bank 0 reg 3, Bank_Switch to 2, write 20 to reg 3 -> bank 2 reads 20. Switch back to 0 -> reads 10. A write in the same cycle as Bank_Switch lands in the old bank.
- Clear: fill bank 1 regs 1..63 with index values, active bank 0, Clear_Req with Clear_Bank=1. Expect Busy high for 63 cycles and one Clear_Done pulse. Concurrent writes to bank 0 succeed. Switching to bank 1 mid-clear shows reg 1 = 0 and reg 63 = 63. After Done, all regs in bank 1 read 0. A second Clear_Req while Busy has no effect.
- Dropped write: active bank = clr_bank while Busy, write 99 to reg 60 -> the bypass shows no 99 and reg 60 reads 0 after Done.
- Reset mid-clear: assert Reset at cycle 30 of the clear -> next cycle Busy=0, Active_Bank=0, every bank reads 0, and no Clear_Done pulse occurs.
